mem_port_ctrl: RTL and testbench

Parametrised memory port controller between the multi-cycle core (datapath/control unit) and the single shared memory bus (readM, writeM, address, inout data). It arbitrates between an instruction-fetch channel and a data load/store channel and inserts a configurable number of memory wait cycles. It also counts completed fetches for the num_inst output. It generalises the fixed single-cycle, single-requester bus usage of the current core to configurable widths and memory latency.

---
 rtl/mem_port_ctrl.sv | 113 +++++++++++
 tb/tb_mem_port_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_ctrl.sv
// Memory port controller: arbitrates a fetch channel and a data channel onto one
// shared memory bus, holding each strobe for LATENCY cycles and counting completed fetches.
module mem_port_ctrl #(
  parameter int WORD_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [WORD_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  output logic [WORD_W-1:0] d_rdata,
  output logic              d_done,
  output logic              readM,
  output logic              writeM,
  output logic [ADDR_W-1:0] address,
  inout  wire  [WORD_W-1:0] data,
  output logic              busy,
  output logic [WORD_W-1:0] num_inst
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t            r_state;
  logic              r_is_data;
  logic [WORD_W-1:0] r_wdata;
  logic [3:0]        r_cnt;

  // Only the controller drives the bus, and only while the write strobe is up.
  assign data = writeM ? r_wdata : {WORD_W{1'bz}};

  // Access sequencer: accept (data first), strobe for LATENCY cycles, one response cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_is_data <= 1'b0;
      r_wdata   <= '0;
      r_cnt     <= 4'd0;
      readM     <= 1'b0;
      writeM    <= 1'b0;
      address   <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_done   <= 1'b0;
      d_done    <= 1'b0;
      busy      <= 1'b0;
      num_inst  <= '0;
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (d_req || if_req) begin
            r_is_data <= d_req;
            r_wdata   <= d_wdata;
            address   <= d_req ? d_addr : if_addr;
            readM     <= !(d_req && d_we);
            writeM    <= d_req && d_we;
            r_cnt     <= CNT_INIT;
            busy      <= 1'b1;
            r_state   <= S_ACCESS;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ACCESS: begin
          if (r_cnt == 4'd0) begin
            readM  <= 1'b0;
            writeM <= 1'b0;
            if (r_is_data) begin
              d_done <= 1'b1;
              if (!writeM) begin
                d_rdata <= data;
              end else begin
                d_rdata <= d_rdata;
              end
            end else begin
              if_done  <= 1'b1;
              if_rdata <= data;
              num_inst <= num_inst + WORD_W'(1);
            end
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          readM   <= 1'b0;
          writeM  <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Self-checking bench for mem_port_ctrl: a LATENCY=2 main instance plus LATENCY=1 and
// LATENCY=15 / WORD_W=4 instances for strobe width and counter wrap-around.
module tb_mem_port_ctrl;
  localparam int L = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [15:0] if_addr = 16'h0, d_addr = 16'h0, d_wdata = 16'h0;
  wire  [15:0] if_rdata, d_rdata, address, num_inst, data;
  wire         if_done, d_done, readM, writeM, busy;

  logic [15:0] mem [256];
  logic [15:0] ref_mem [256];
  logic [15:0] exp_if_rdata = 16'h0, exp_d_rdata = 16'h0, exp_num = 16'h0;

  // Memory answers reads combinationally from its array.
  assign data = readM ? mem[address[7:0]] : 16'hzzzz;

  mem_port_ctrl #(.WORD_W(16), .ADDR_W(16), .LATENCY(L)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .readM(readM), .writeM(writeM), .address(address), .data(data),
    .busy(busy), .num_inst(num_inst)
  );

  logic        l1_if_req = 1'b0;
  logic [15:0] l1_if_addr = 16'h0;
  wire  [15:0] l1_if_rdata, l1_d_rdata, l1_address, l1_num_inst, l1_data;
  wire         l1_if_done, l1_d_done, l1_readM, l1_writeM, l1_busy;
  assign l1_data = l1_readM ? (l1_address ^ 16'h5A5A) : 16'hzzzz;

  mem_port_ctrl #(.WORD_W(16), .ADDR_W(16), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .reset_n(reset_n),
    .if_req(l1_if_req), .if_addr(l1_if_addr), .if_rdata(l1_if_rdata), .if_done(l1_if_done),
    .d_req(1'b0), .d_we(1'b0), .d_addr(16'h0), .d_wdata(16'h0),
    .d_rdata(l1_d_rdata), .d_done(l1_d_done),
    .readM(l1_readM), .writeM(l1_writeM), .address(l1_address), .data(l1_data),
    .busy(l1_busy), .num_inst(l1_num_inst)
  );

  logic       l15_if_req = 1'b0;
  logic [7:0] l15_if_addr = 8'h0;
  wire  [3:0] l15_if_rdata, l15_d_rdata, l15_num_inst, l15_data;
  wire  [7:0] l15_address;
  wire        l15_if_done, l15_d_done, l15_readM, l15_writeM, l15_busy;
  assign l15_data = l15_readM ? (l15_address[3:0] ^ 4'h9) : 4'hz;

  mem_port_ctrl #(.WORD_W(4), .ADDR_W(8), .LATENCY(15)) u_dut_l15 (
    .clk(clk), .reset_n(reset_n),
    .if_req(l15_if_req), .if_addr(l15_if_addr), .if_rdata(l15_if_rdata), .if_done(l15_if_done),
    .d_req(1'b0), .d_we(1'b0), .d_addr(8'h0), .d_wdata(4'h0),
    .d_rdata(l15_d_rdata), .d_done(l15_d_done),
    .readM(l15_readM), .writeM(l15_writeM), .address(l15_address), .data(l15_data),
    .busy(l15_busy), .num_inst(l15_num_inst)
  );

  task automatic issue(input bit is_data, input bit we, input logic [15:0] addr, input logic [15:0] wdata);
    if (is_data) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
  endtask

  // Walks one access from the cycle after acceptance through the following IDLE cycle.
  task automatic follow(input bit is_data, input bit we, input logic [15:0] addr, input logic [15:0] wdata);
    bit rd;
    rd = !(is_data && we);
    for (int k = 1; k <= L; k++) begin
      @(negedge clk);
      checks++;
      if (readM !== rd || writeM !== !rd || address !== addr || busy !== 1'b1 ||
          if_done !== 1'b0 || d_done !== 1'b0) begin
        failures++;
        $display("FAIL strobe cyc%0d: got readM=%b writeM=%b addr=%h busy=%b done=%b%b, want readM=%b writeM=%b addr=%h busy=1 done=00",
                 k, readM, writeM, address, busy, if_done, d_done, rd, !rd, addr);
      end
      if (!rd) begin
        checks++;
        if (data !== wdata) begin
          failures++;
          $display("FAIL store_data cyc%0d: got %h want %h", k, data, wdata);
        end
        mem[address[7:0]] = data;
      end
      if (is_data) begin
        d_addr = 16'($urandom); d_wdata = 16'($urandom); d_we = 1'($urandom);
      end else begin
        if_addr = 16'($urandom);
      end
    end
    @(negedge clk);
    if (is_data) begin
      if (!we) exp_d_rdata = ref_mem[addr[7:0]];
      else ref_mem[addr[7:0]] = wdata;
    end else begin
      exp_if_rdata = ref_mem[addr[7:0]];
      exp_num = exp_num + 16'd1;
    end
    checks++;
    if (if_done !== !is_data || d_done !== is_data || readM !== 1'b0 || writeM !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL resp: got if_done=%b d_done=%b readM=%b writeM=%b busy=%b, want if_done=%b d_done=%b 0 0 1",
               if_done, d_done, readM, writeM, busy, !is_data, is_data);
    end
    checks++;
    if (if_rdata !== exp_if_rdata || d_rdata !== exp_d_rdata || num_inst !== exp_num) begin
      failures++;
      $display("FAIL result: got if_rdata=%h d_rdata=%h num_inst=%0d, want %h %h %0d",
               if_rdata, d_rdata, num_inst, exp_if_rdata, exp_d_rdata, exp_num);
    end
    if (is_data) d_req = 1'b0; else if_req = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || if_done !== 1'b0 || d_done !== 1'b0 || readM !== 1'b0 || writeM !== 1'b0) begin
      failures++;
      $display("FAIL idle: got busy=%b done=%b%b readM=%b writeM=%b, want all 0",
               busy, if_done, d_done, readM, writeM);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (readM !== 1'b0 || writeM !== 1'b0 || busy !== 1'b0 || if_done !== 1'b0 || d_done !== 1'b0 ||
        address !== 16'h0 || if_rdata !== 16'h0 || d_rdata !== 16'h0 || num_inst !== 16'h0) begin
      failures++;
      $display("FAIL reset: got readM=%b writeM=%b busy=%b addr=%h if_rdata=%h d_rdata=%h num_inst=%h, want all 0",
               readM, writeM, busy, address, if_rdata, d_rdata, num_inst);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fetch;
    mem[16] = 16'h6A05; ref_mem[16] = 16'h6A05;
    issue(1'b0, 1'b0, 16'h0010, 16'h0);
    follow(1'b0, 1'b0, 16'h0010, 16'h0);
  endtask

  task automatic test_store_load;
    issue(1'b1, 1'b1, 16'h0020, 16'hBEEF);
    follow(1'b1, 1'b1, 16'h0020, 16'hBEEF);
    issue(1'b1, 1'b0, 16'h0020, 16'h0);
    follow(1'b1, 1'b0, 16'h0020, 16'h0);
  endtask

  task automatic test_arbitration;
    logic [15:0] fa, da;
    for (int n = 0; n < 3; n++) begin
      fa = 16'($urandom_range(0, 255));
      da = 16'($urandom_range(0, 255));
      issue(1'b0, 1'b0, fa, 16'h0);
      issue(1'b1, 1'b0, da, 16'h0);
      follow(1'b1, 1'b0, da, 16'h0);
      follow(1'b0, 1'b0, fa, 16'h0);
    end
  endtask

  task automatic test_random;
    int kind;
    logic [15:0] a, w;
    for (int n = 0; n < 24; n++) begin
      kind = $urandom_range(0, 3);
      a = 16'($urandom_range(0, 255));
      w = 16'($urandom);
      issue(kind >= 2, kind == 3, a, w);
      follow(kind >= 2, kind == 3, a, w);
    end
  endtask

  task automatic test_reset_mid_access;
    issue(1'b0, 1'b0, 16'h0033, 16'h0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (readM !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_strobe: got readM=%b want 1", readM);
    end
    reset_n = 1'b0;
    if_req = 1'b0;
    exp_num = 16'h0; exp_if_rdata = 16'h0; exp_d_rdata = 16'h0;
    #1;
    checks++;
    if (readM !== 1'b0 || writeM !== 1'b0 || busy !== 1'b0 || num_inst !== exp_num) begin
      failures++;
      $display("FAIL mid_reset: got readM=%b writeM=%b busy=%b num_inst=%0d, want 0 0 0 %0d",
               readM, writeM, busy, num_inst, exp_num);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (if_done !== 1'b0 || num_inst !== exp_num || busy !== 1'b0) begin
        failures++;
        $display("FAIL after_reset: got if_done=%b num_inst=%0d busy=%b, want 0 %0d 0",
                 if_done, num_inst, busy, exp_num);
      end
    end
  endtask

  task automatic test_lat1;
    logic [15:0] a, en;
    int cyc, wid;
    en = 16'h0;
    for (int n = 0; n < 6; n++) begin
      a = 16'($urandom);
      l1_if_addr = a; l1_if_req = 1'b1;
      cyc = 0; wid = 0;
      do begin
        @(negedge clk);
        cyc++;
        if (l1_readM) wid++;
      end while (!l1_if_done && cyc < 40);
      en = en + 16'd1;
      checks++;
      if (wid != 1 || cyc != 2) begin
        failures++;
        $display("FAIL lat1_timing: got width=%0d done_at=%0d, want 1 2", wid, cyc);
      end
      checks++;
      if (l1_if_rdata !== (a ^ 16'h5A5A) || l1_num_inst !== en) begin
        failures++;
        $display("FAIL lat1_data: got rdata=%h num=%0d, want %h %0d", l1_if_rdata, l1_num_inst, a ^ 16'h5A5A, en);
      end
      l1_if_req = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_lat15_wrap;
    logic [7:0] a;
    logic [3:0] en, er;
    int cyc, wid;
    en = 4'h0;
    for (int n = 0; n < 17; n++) begin
      a = 8'($urandom);
      er = a[3:0] ^ 4'h9;
      l15_if_addr = a; l15_if_req = 1'b1;
      cyc = 0; wid = 0;
      do begin
        @(negedge clk);
        cyc++;
        if (l15_readM) wid++;
      end while (!l15_if_done && cyc < 40);
      en = en + 4'd1;
      checks++;
      if (wid != 15 || cyc != 16) begin
        failures++;
        $display("FAIL lat15_timing: got width=%0d done_at=%0d, want 15 16", wid, cyc);
      end
      checks++;
      if (l15_if_rdata !== er || l15_num_inst !== en) begin
        failures++;
        $display("FAIL lat15_data: got rdata=%h num=%0d, want %h %0d", l15_if_rdata, l15_num_inst, er, en);
      end
      l15_if_req = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'($urandom);
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_fetch();
    test_store_load();
    test_arbitration();
    test_random();
    test_reset_mid_access();
    test_lat1();
    test_lat15_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
